// File: rtl/fpu_resp_buffer_if.sv
// Request/grant and result signals between the interconnect, the FPU and the response buffer.
// The slave modport is the buffer's view; master is the surrounding environment.
interface fpu_resp_buffer_if #(
  parameter int ID_WIDTH        = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int DEPTH           = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       req_i;
  logic                       gnt_o;
  logic                       fpu_req_o;
  logic                       fpu_gnt_i;
  logic                       fpu_rvalid_i;
  logic [DATA_WIDTH-1:0]      fpu_rdata_i;
  logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i;
  logic [ID_WIDTH-1:0]        fpu_rID_i;
  logic                       rvalid_o;
  logic                       rready_i;
  logic [DATA_WIDTH-1:0]      rdata_o;
  logic [FLAGS_OUT_WIDTH-1:0] rflags_o;
  logic [ID_WIDTH-1:0]        rID_o;
  logic [CNT_W-1:0]           outstanding_o;
  logic                       idle_o;
  logic                       overflow_o;

  modport slave (
    input  req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i, rready_i,
    output gnt_o, fpu_req_o, rvalid_o, rdata_o, rflags_o, rID_o, outstanding_o, idle_o, overflow_o
  );

  modport master (
    output req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i, rready_i,
    input  gnt_o, fpu_req_o, rvalid_o, rdata_o, rflags_o, rID_o, outstanding_o, idle_o, overflow_o
  );
endinterface

// File: rtl/fpu_resp_buffer.sv
// Credit gate and result FIFO in front of an FPU whose result port cannot be stalled.
// Requests pass only while a result slot is reserved; results are replayed with valid/ready.
module fpu_resp_buffer #(
  parameter int ID_WIDTH        = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int DEPTH           = 4
) (
  input logic               clk,
  input logic               rst_n,
  fpu_resp_buffer_if.slave  bus
);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ID_WIDTH + FLAGS_OUT_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   occ;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               overflow;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic credit_ok;
  logic accept;
  logic pop;
  logic push;
  logic full;
  logic wr_en;
  logic cnt_inc;
  logic cnt_dec;

  assign credit_ok = (cnt < FULL);
  assign accept    = bus.req_i & bus.fpu_gnt_i & credit_ok;
  assign pop       = bus.rvalid_o & bus.rready_i;
  assign push      = bus.fpu_rvalid_i;
  assign full      = (occ == FULL);
  // A simultaneous pop frees the slot the push is about to land in.
  assign wr_en     = push & (~full | pop);

  // The decrement guard only matters if a non-compliant FPU pushed more results than were granted.
  assign cnt_inc = accept & ~pop;
  assign cnt_dec = pop & ~accept & (cnt != '0);

  assign bus.fpu_req_o     = bus.req_i & credit_ok;
  assign bus.gnt_o         = bus.fpu_gnt_i & credit_ok;
  assign bus.rvalid_o      = (occ != '0);
  assign bus.outstanding_o = cnt;
  assign bus.idle_o        = (cnt == '0);
  assign bus.overflow_o    = overflow;
  assign {bus.rID_o, bus.rflags_o, bus.rdata_o} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (wr_en & ~pop) begin
        occ <= occ + CNT_W'(1);
      end else if (pop & ~wr_en) begin
        occ <= occ - CNT_W'(1);
      end

      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if (push & full & ~pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is intentionally left out of reset; the head is only meaningful while rvalid_o is high.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {bus.fpu_rID_i, bus.fpu_rflags_i, bus.fpu_rdata_i};
    end
  end
endmodule

// File: doc/fpu_resp_buffer.md
# fpu_resp_buffer

Response buffer and credit gate between the APU/FPU interconnect and the FPU wrapper, whose result port has no backpressure (its result-ready is tied high and results are produced unconditionally). The block forwards requests to the FPU only while a result slot is guaranteed free. It captures every FPU result into a DEPTH-entry FIFO and re-presents results to the interconnect with a proper valid/ready handshake. It sits directly downstream of the FPU result port and in-line on its request/grant pair.

## Interface
- ID_WIDTH, 9, width of request/response tag
- DATA_WIDTH, 32, result width
- FLAGS_OUT_WIDTH, 5, status flag width
- DEPTH, 4, FIFO entries and maximum credits; power of two, >= 2
- CNT_W, $clog2(DEPTH+1), credit counter width (derived, not overridden)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_i  in  1  request from interconnect
- gnt_o  out  1  grant to interconnect
- fpu_req_o  out  1  request to FPU
- fpu_gnt_i  in  1  grant (in_ready) from FPU
- fpu_rvalid_i  in  1  FPU result valid; no backpressure possible
- fpu_rdata_i  in  DATA_WIDTH  FPU result
- fpu_rflags_i  in  FLAGS_OUT_WIDTH  FPU status flags
- fpu_rID_i  in  ID_WIDTH  FPU result tag
- rvalid_o  out  1  buffered result valid
- rready_i  in  1  interconnect accepts result
- rdata_o  out  DATA_WIDTH  head-of-FIFO result
- rflags_o  out  FLAGS_OUT_WIDTH  head-of-FIFO flags
- rID_o  out  ID_WIDTH  head-of-FIFO tag
- outstanding_o  out  CNT_W  in-flight plus buffered operations
- idle_o  out  1  outstanding_o == 0
- overflow_o  out  1  sticky: push attempted while FIFO full and no pop

## Operation
- credit_ok = (cnt < DEPTH); fpu_req_o = req_i & credit_ok; gnt_o = fpu_gnt_i & credit_ok (combinational, no added latency on the request path).
- accept = fpu_req_o & fpu_gnt_i; pop = rvalid_o & rready_i; push = fpu_rvalid_i.
- cnt: +1 on accept only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH or underflows.
- FIFO: circular, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH, plus occupancy counter 0..DEPTH. Push writes {rID, rflags, rdata} at wr_ptr. Pop advances rd_ptr.
- Full FIFO with push and pop in the same cycle: both take effect, occupancy unchanged.
- Full FIFO with push and no pop: write dropped, pointers unchanged, overflow_o set until reset. This cannot occur with a compliant FPU, because credits bound occupancy.
- Empty FIFO with pop: impossible, since rvalid_o = (occupancy != 0).
- Result order is FIFO order of arrival. Tags are passed through, not interpreted.
- Outputs rdata_o/rflags_o/rID_o are read combinationally from storage at rd_ptr. They are stable while rvalid_o & !rready_i.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally): cnt=0, occupancy=0, pointers=0, overflow_o=0.
- Output values in reset: rvalid_o=0, idle_o=1, outstanding_o=0, fpu_req_o=0 and gnt_o=0 unless req_i/fpu_gnt_i (combinational paths stay live).
- Storage contents are not reset; rdata_o/rflags_o/rID_o are don't-care while rvalid_o=0.
- Push at edge N makes rvalid_o=1 in cycle N+1. No same-cycle bypass: the minimum added latency is 1 cycle.
- Pop at edge N: the next entry (if any) is presented in cycle N+1. Back-to-back pops sustain 1 result per cycle.
- A credit freed by a pop at edge N allows gnt_o in cycle N+1.
- Reset mid-operation discards all buffered and in-flight accounting; the FPU shares rst_n, so no stale results follow.

## Test plan
- Single op: req_i=1, fpu_gnt_i=1 for 1 cycle, FPU returns data=32'h3F800000, ID=5 three cycles later, rready_i=1 -> rvalid_o one cycle after push with the same data/ID; outstanding_o goes 1->0; idle_o=1 afterwards.
- Credit exhaustion (DEPTH=4): issue 4 accepts with rready_i=0, hold req_i=1 -> gnt_o=0 and fpu_req_o=0 from the cycle cnt=4. Pop one result -> gnt_o=1 the next cycle.
- Simultaneous accept and pop at cnt=3 -> cnt stays 3; a push in the same cycle as a pop with occupancy 4 -> occupancy stays 4, data order preserved.
- Wrap-around: stream 10 ops with IDs 0..9 and random rready_i -> rID_o sequence is exactly 0..9, no loss, overflow_o=0.
- Protocol violation: force fpu_rvalid_i while occupancy=4 and rready_i=0 -> entry dropped, overflow_o=1 and held; stored entries unchanged.
- Reset mid-stream with occupancy=2, cnt=3 -> rvalid_o=0, outstanding_o=0, overflow_o=0 immediately on rst_n low.
